// File: rtl/fnv1a_hash_sequencer.sv
// Opcode/payload sequencer feeding a 32-bit FNV-1a accumulator, digest readback over the byte stream.
// Latency: one absorbed byte per 3 cycles (ABSORB->MUL1->MUL2); digest updates at the end of MUL2.
// Backpressure: rx_ready drops during MUL1/MUL2; tx bytes advance only on tx_ready.
module fnv1a_hash_sequencer #(
    parameter logic [31:0] OFFSET_BASIS = 32'h811C9DC5,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             txn_start,
    input  logic             txn_is_read,
    input  logic             txn_stop,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [31:0]      digest,
    output logic [CNT_W-1:0] byte_count,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE, S_OPCODE, S_ABSORB, S_DISCARD, S_MUL1, S_MUL2, S_READ
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_hash;
    logic [31:0]      r_hx;
    logic [31:0]      r_p;
    logic [31:0]      r_snap;
    logic [1:0]       r_idx;
    logic [CNT_W-1:0] r_count;
    logic             r_err;
    logic             r_pend_start;
    logic             r_pend_read;
    logic             r_pend_stop;
    logic             r_start_last;

    logic             w_evt;
    logic             w_xfer;
    logic             w_snap;
    logic             w_clear;
    logic             w_set_err;
    logic             w_load_hx;
    logic             w_pend_start;
    logic             w_pend_read;
    logic             w_pend_stop;
    logic             w_start_last;
    logic [31:0]      w_mul_res;
    logic [31:0]      w_snap_val;

    // Pending view including events arriving in the MUL2 exit cycle itself
    assign w_pend_start = r_pend_start | txn_start;
    assign w_pend_read  = txn_start ? txn_is_read : r_pend_read;
    assign w_pend_stop  = r_pend_stop | txn_stop;
    // Start wins a same-cycle tie, otherwise whichever event arrived last
    assign w_start_last = txn_start | (~txn_stop & r_start_last);

    // Second half of the prime multiply: p + hx*(2^7 + 2^8 + 2^24)
    assign w_mul_res  = r_p + (r_hx << 7) + (r_hx << 8) + (r_hx << 24);
    // Snapshot must see the freshly multiplied hash when READ is entered from MUL2
    assign w_snap_val = (r_state == S_MUL2) ? w_mul_res : r_hash;

    assign digest     = r_hash;
    assign byte_count = r_count;
    assign err        = r_err;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode, handshake outputs and datapath enables
    always_comb begin
        w_next    = r_state;
        rx_ready  = 1'b0;
        tx_valid  = 1'b0;
        busy      = 1'b0;
        w_xfer    = 1'b0;
        w_snap    = 1'b0;
        w_clear   = 1'b0;
        w_set_err = 1'b0;
        w_load_hx = 1'b0;
        w_evt     = txn_start | txn_stop;
        case (r_state)
            S_MUL1: begin
                busy   = 1'b1;
                w_next = S_MUL2;
            end
            S_MUL2: begin
                busy = 1'b1;
                if (w_pend_start && (!w_pend_stop || w_start_last)) begin
                    w_next = w_pend_read ? S_READ : S_OPCODE;
                    w_snap = w_pend_read;
                end else if (w_pend_stop) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_ABSORB;
                end
            end
            default: begin
                rx_ready = (r_state == S_OPCODE) || (r_state == S_ABSORB) ||
                           (r_state == S_DISCARD);
                tx_valid = (r_state == S_READ);
                // Bytes coinciding with a bus event are dropped
                w_xfer   = rx_ready & rx_valid & ~w_evt;
                if (txn_start) begin
                    w_next = txn_is_read ? S_READ : S_OPCODE;
                    w_snap = txn_is_read;
                end else if (txn_stop) begin
                    w_next = S_IDLE;
                end else if (w_xfer) begin
                    case (r_state)
                        S_OPCODE: begin
                            if (rx_data == 8'h00) begin
                                w_clear = 1'b1;
                                w_next  = S_DISCARD;
                            end else if (rx_data == 8'h01) begin
                                w_next  = S_ABSORB;
                            end else begin
                                w_set_err = 1'b1;
                                w_next    = S_DISCARD;
                            end
                        end
                        S_ABSORB: begin
                            w_load_hx = 1'b1;
                            w_next    = S_MUL1;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Digest byte mux, MSB first; zero outside READ
    always_comb begin
        tx_data = 8'h00;
        if (tx_valid) begin
            case (r_idx)
                2'd0:    tx_data = r_snap[31:24];
                2'd1:    tx_data = r_snap[23:16];
                2'd2:    tx_data = r_snap[15:8];
                default: tx_data = r_snap[7:0];
            endcase
        end
    end

    // Hash datapath, counters, error flag and readback snapshot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hash  <= OFFSET_BASIS;
            r_hx    <= 32'h0;
            r_p     <= 32'h0;
            r_snap  <= 32'h0;
            r_idx   <= 2'd0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_clear) begin
                r_hash  <= OFFSET_BASIS;
                r_count <= '0;
                r_err   <= 1'b0;
            end
            if (w_set_err)
                r_err <= 1'b1;
            if (w_load_hx)
                r_hx <= r_hash ^ {24'h0, rx_data};
            if (r_state == S_MUL1)
                r_p <= r_hx + (r_hx << 1) + (r_hx << 4);
            if (r_state == S_MUL2) begin
                r_hash <= w_mul_res;
                if (r_count != {CNT_W{1'b1}})
                    r_count <= r_count + CNT_ONE;
            end
            if (w_snap) begin
                r_snap <= w_snap_val;
                r_idx  <= 2'd0;
            end else if (tx_valid && tx_ready) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // Latch bus events seen mid-multiply; consumed on MUL2 exit
    always_ff @(posedge clk) begin
        if (reset || r_state == S_MUL2 || r_state != S_MUL1) begin
            r_pend_start <= 1'b0;
            r_pend_read  <= 1'b0;
            r_pend_stop  <= 1'b0;
            r_start_last <= 1'b0;
        end else begin
            if (txn_start) begin
                r_pend_start <= 1'b1;
                r_pend_read  <= txn_is_read;
            end
            if (txn_stop)
                r_pend_stop <= 1'b1;
            r_start_last <= w_start_last;
        end
    end

endmodule
